// File: rtl/mem_subsys_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_subsys_pkg
// Description : Shared encodings and lane helpers for the data-memory
//               controller (access sizes, FSM states, byte enables, load
//               lane selection with sign/zero extension).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_subsys_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Pick the addressed lane out of a word and sign- or zero-extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: res = {{24{~uns & sh[7]}}, sh[7:0]};
      SZ_HALF: res = {{16{~uns & sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_sram.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_sram
// Description : DEPTH_WORDS x 32 single-port synchronous RAM with four byte
//               write enables and a registered (one-cycle) read.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_sram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en_i,
  input  logic [3:0]                     we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-lane writes and read-before-write data capture on enabled cycles.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_subsys_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_subsys_ctrl
// Description : Registered request/response data-memory controller with
//               byte/half/word access, wait states, error reporting and a
//               memory-mapped LED register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_subsys_ctrl
  import mem_subsys_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] LED_ADDR    = 32'h0000_2000,
  parameter int          LED_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [LED_W-1:0] led
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] LED_MASK  = 32'hFFFF_FFFF >> (32 - LED_W);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] led_q, led_d;

  // In IDLE the live request is decoded so that a zero-wait store can commit
  // on its accept edge; afterwards the latched copy is used.
  logic        cur_sel;
  logic [31:0] cur_addr, cur_wdata;
  logic        cur_we;
  logic [1:0]  cur_size;
  logic        in_ram, led_hit, cur_err, enter_resp, commit;
  logic [3:0]  be;
  logic [31:0] wdata_rep, ram_rdata;

  assign cur_sel   = (state_q == ST_IDLE);
  assign cur_addr  = cur_sel ? req_addr  : addr_q;
  assign cur_wdata = cur_sel ? req_wdata : wdata_q;
  assign cur_we    = cur_sel ? req_we    : we_q;
  assign cur_size  = cur_sel ? req_size  : size_q;

  assign in_ram  = (cur_addr[31:AW+2] == '0);
  assign led_hit = (cur_addr[31:2] == LED_ADDR[31:2]);
  assign cur_err = (cur_size == 2'd3)
                 || ((cur_size == SZ_HALF) && cur_addr[0])
                 || ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00))
                 || !(in_ram || led_hit);

  assign be         = byte_en(cur_size, cur_addr[1:0]);
  assign wdata_rep  = (cur_size == SZ_BYTE) ? {4{cur_wdata[7:0]}}  :
                      (cur_size == SZ_HALF) ? {2{cur_wdata[15:0]}} : cur_wdata;
  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign commit     = enter_resp && !cur_err;

  mem_byte_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk     (clk),
    .en_i    (commit && in_ram),
    .we_i    (cur_we ? be : 4'b0000),
    .addr_i  (cur_addr[AW+1:2]),
    .wdata_i (wdata_rep),
    .rdata_o (ram_rdata)
  );

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE -> (WAIT x WAIT_STATES) -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the request fields on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
    end else if (cur_sel && req_valid) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
    end
  end

  // LED lane merge; bits above LED_W are held at zero so loads see padding.
  always_comb begin
    led_d = led_q;
    if (commit && led_hit && cur_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) led_d[8*i +: 8] = wdata_rep[8*i +: 8];
      end
      led_d = led_d & LED_MASK;
    end
  end

  // LED register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= 32'd0;
    else        led_q <= led_d;
  end

  assign led       = led_q[LED_W-1:0];
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid && cur_err;
  assign rsp_rdata = (rsp_valid && !cur_err && !we_q)
                   ? load_ext(led_hit ? led_q : ram_rdata, size_q, addr_q[1:0], uns_q)
                   : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_subsys_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_subsys_ctrl
// Description : Self-checking bench: directed vector table, randomized
//               traffic against a byte-addressed reference model, reset
//               during a wait state, and zero-wait back-to-back traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_subsys_ctrl;
  import mem_subsys_pkg::*;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] LEDA  = 32'h0000_2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned, rsp_valid, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_size;
  logic [7:0]  led;

  logic        b_valid, b_ready, b_we, b_uns, b_rsp_valid, b_rsp_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [1:0]  b_size;
  logic [7:0]  b_led;

  mem_subsys_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1), .LED_ADDR(LEDA), .LED_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .led(led)
  );

  mem_subsys_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .LED_ADDR(LEDA), .LED_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_we(b_we), .req_size(b_size),
    .req_unsigned(b_uns), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata),
    .rsp_err(b_rsp_err), .led(b_led)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed RAM image (first 256 bytes) and LED value.
  logic [7:0]  bmem [256];
  logic [31:0] led_m;

  task automatic model_op(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] erd, output logic eerr);
    int     n;
    bit     hit;
    longint v;
    n    = 1 << sz;
    hit  = (a[31:2] == LEDA[31:2]);
    eerr = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
        || !((a < DEPTH * 4) || hit);
    erd  = 32'd0;
    if (!eerr) begin
      if (we) begin
        for (int k = 0; k < n; k++) begin
          if (hit) led_m[(int'(a[1:0]) + k) * 8 +: 8] = wd[8*k +: 8];
          else     bmem[a + k] = wd[8*k +: 8];
        end
        led_m = led_m & 32'h0000_00FF;
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) begin
          if (hit) v = v | (longint'(led_m[(int'(a[1:0]) + k) * 8 +: 8]) << (8 * k));
          else     v = v | (longint'(bmem[a + k]) << (8 * k));
        end
        if (!uns && v[8*n-1]) v = v - (64'd1 << (8 * n));
        erd = v[31:0];
      end
    end
  endtask

  // One complete transaction on u_dut including latency/handshake checks.
  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
    int lat;
    int rlo;
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_we = ~we; req_size = 2'($urandom); req_unsigned = ~uns;
    lat = 1;
    rlo = 0;
    while (!rsp_valid && lat < 20) begin
      if (!req_ready) rlo++;
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    if (!req_ready) rlo++;
    chk("latency", lat, 2);
    chk("ready_low_cycles", rlo, 2);
    @(negedge clk);
    chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [7:0]  exp_led;
  } vec_t;

  function automatic vec_t mk(logic we, logic [1:0] sz, logic uns, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] erd, logic eerr, logic [7:0] eled);
    vec_t v;
    v.we = we; v.sz = sz; v.uns = uns; v.a = a; v.wd = wd;
    v.exp_rd = erd; v.exp_err = eerr; v.exp_led = eled;
    return v;
  endfunction

  vec_t tbl [19];

  initial begin
    logic [31:0] rd, erd, prior;
    logic        er, eerr;
    logic [31:0] baddr [6];
    logic [31:0] bwd [6];
    logic [31:0] bexp [6];
    logic        bwe [6];
    int          acc [6];
    int          nacc, nresp;
    logic        prev, adv;

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    b_valid = 1'b0; b_we = 1'b0; b_size = 2'd0; b_uns = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_led", {24'd0, led}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", {31'd0, req_ready}, 32'd1);

    // Directed vectors
    tbl[0]  = mk(1, SZ_WORD, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, 8'h00);
    tbl[1]  = mk(0, SZ_WORD, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 8'h00);
    tbl[2]  = mk(1, SZ_WORD, 0, 32'h10,   32'h11223344, 32'h0,        0, 8'h00);
    tbl[3]  = mk(1, SZ_BYTE, 0, 32'h13,   32'hABCDEF80, 32'h0,        0, 8'h00);
    tbl[4]  = mk(0, SZ_BYTE, 0, 32'h13,   32'h0,        32'hFFFFFF80, 0, 8'h00);
    tbl[5]  = mk(0, SZ_BYTE, 1, 32'h13,   32'h0,        32'h00000080, 0, 8'h00);
    tbl[6]  = mk(0, SZ_WORD, 0, 32'h10,   32'h0,        32'h80223344, 0, 8'h00);
    tbl[7]  = mk(1, SZ_HALF, 0, 32'h2000, 32'h0000A5A5, 32'h0,        0, 8'hA5);
    tbl[8]  = mk(0, SZ_WORD, 0, 32'h2000, 32'h0,        32'h000000A5, 0, 8'hA5);
    tbl[9]  = mk(0, SZ_HALF, 0, 32'h11,   32'h0,        32'h0,        1, 8'hA5);
    tbl[10] = mk(1, SZ_WORD, 0, 32'h12,   32'h55555555, 32'h0,        1, 8'hA5);
    tbl[11] = mk(0, SZ_WORD, 0, 32'h1000, 32'h0,        32'h0,        1, 8'hA5);
    tbl[12] = mk(1, 2'd3,    0, 32'h10,   32'hFFFFFFFF, 32'h0,        1, 8'hA5);
    tbl[13] = mk(1, SZ_BYTE, 0, 32'h2001, 32'h00000077, 32'h0,        0, 8'hA5);
    tbl[14] = mk(0, SZ_WORD, 0, 32'h10,   32'h0,        32'h80223344, 0, 8'hA5);
    tbl[15] = mk(0, SZ_WORD, 0, 32'h2000, 32'h0,        32'h000000A5, 0, 8'hA5);
    tbl[16] = mk(0, SZ_BYTE, 0, 32'h2000, 32'h0,        32'hFFFFFFA5, 0, 8'hA5);
    tbl[17] = mk(0, SZ_HALF, 0, 32'h12,   32'h0,        32'hFFFF8022, 0, 8'hA5);
    tbl[18] = mk(0, SZ_HALF, 1, 32'h12,   32'h0,        32'h00008022, 0, 8'hA5);

    for (int i = 0; i < 19; i++) begin
      xact(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
      chk($sformatf("vec%0d_led", i), {24'd0, led}, {24'd0, tbl[i].exp_led});
    end

    // Initialize the modelled RAM window, then randomized traffic
    led_m = 32'h0000_00A5;
    for (int w = 0; w < 64; w++) begin
      prior = $urandom;
      model_op(1'b1, SZ_WORD, 1'b0, 32'(w * 4), prior, erd, eerr);
      xact(1'b1, SZ_WORD, 1'b0, 32'(w * 4), prior, rd, er);
    end
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, wd;
      logic [1:0]  sz;
      logic        we, uns;
      int          r;
      r  = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 3));
      if (r < 7)      a = 32'($urandom_range(0, 255));
      else if (r < 9) a = LEDA + 32'($urandom_range(0, 3));
      else            a = 32'h1000 + 32'($urandom_range(0, 4095));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom;
      model_op(we, sz, uns, a, wd, erd, eerr);
      xact(we, sz, uns, a, wd, rd, er);
      chk($sformatf("rnd%0d_rdata", i), rd, erd);
      chk($sformatf("rnd%0d_err", i), {31'd0, er}, {31'd0, eerr});
      chk($sformatf("rnd%0d_led", i), {24'd0, led}, {24'd0, led_m[7:0]});
    end

    // Reset asserted while a store waits
    model_op(1'b1, SZ_BYTE, 1'b0, LEDA, 32'h3C, erd, eerr);
    xact(1'b1, SZ_BYTE, 1'b0, LEDA, 32'h3C, rd, er);
    chk("led_before_reset", {24'd0, led}, 32'h3C);
    prior = {bmem[35], bmem[34], bmem[33], bmem[32]};
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("in_wait_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_reset_led", {24'd0, led}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_reset_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    led_m = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("after_reset_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    xact(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, rd, er);
    chk("dropped_store_rdata", rd, prior);
    chk("dropped_store_led", {24'd0, led}, 32'd0);

    // Zero-wait back-to-back traffic with req_valid held high
    bwe[0] = 1; baddr[0] = 32'h0; bwd[0] = 32'hA0000001; bexp[0] = 32'h0;
    bwe[1] = 1; baddr[1] = 32'h4; bwd[1] = 32'hB0000002; bexp[1] = 32'h0;
    bwe[2] = 1; baddr[2] = 32'h8; bwd[2] = 32'hC0000003; bexp[2] = 32'h0;
    bwe[3] = 0; baddr[3] = 32'h8; bwd[3] = 32'h0;        bexp[3] = 32'hC0000003;
    bwe[4] = 0; baddr[4] = 32'h4; bwd[4] = 32'h0;        bexp[4] = 32'hB0000002;
    bwe[5] = 0; baddr[5] = 32'h0; bwd[5] = 32'h0;        bexp[5] = 32'hA0000001;
    @(negedge clk);
    b_we = bwe[0]; b_addr = baddr[0]; b_wdata = bwd[0]; b_size = SZ_WORD; b_uns = 1'b0;
    b_valid = 1'b1;
    nacc = 0; nresp = 0; prev = 1'b0; adv = 1'b0;
    for (int cyc = 0; cyc < 40 && nresp < 6; cyc++) begin
      if (adv) begin
        if (nacc < 6) begin b_we = bwe[nacc]; b_addr = baddr[nacc]; b_wdata = bwd[nacc]; end
        else          b_valid = 1'b0;
        adv = 1'b0;
      end
      if (b_rsp_valid) begin
        chk($sformatf("b2b%0d_rdata", nresp), b_rdata, bexp[nresp]);
        chk($sformatf("b2b%0d_err", nresp), {31'd0, b_rsp_err}, 32'd0);
        chk($sformatf("b2b%0d_single", nresp), {31'd0, prev}, 32'd0);
        chk($sformatf("b2b%0d_latency", nresp), 32'(cyc - acc[nresp]), 32'd1);
        nresp++;
      end
      prev = b_rsp_valid;
      if (b_ready && b_valid && nacc < 6) begin
        acc[nacc] = cyc;
        if (nacc > 0) chk($sformatf("b2b%0d_spacing", nacc), 32'(cyc - acc[nacc-1]), 32'd2);
        nacc++;
        adv = 1'b1;
      end
      @(negedge clk);
    end
    chk("b2b_responses", 32'(nresp), 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
